div_ctrl: RTL

Request-side controller for the 32-bit iterative unsigned divider core in the execute stage. It accepts RISC-V M-extension divide/remainder operations (DIV, DIVU, REM, REMU) over a valid/ready interface and resolves divide-by-zero and signed overflow locally in one cycle. All other operations it converts to magnitudes, issues to the divider core, captures the core's `{rem, quo}` result, applies the sign correction, and returns one 32-bit result over a valid/ready response port.

---
 rtl/div_ctrl_pkg.sv | 34 +++
 rtl/div_sign_fix.sv | 24 ++
 rtl/div_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divide request controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } div_state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  // Core result layout: {rem, quo}
  localparam int REM_HI = 63;
  localparam int REM_LO = 32;

  function automatic logic op_signed(div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Selects quotient or remainder from the unsigned core result and restores
// the sign. Sign flags arrive pre-qualified (already zero for unsigned ops).
module div_sign_fix
  import div_ctrl_pkg::*;
(
  input  logic [63:0] dv_c_i,
  input  div_op_t     op_i,
  input  logic        a_neg_i,
  input  logic        b_neg_i,
  output logic [31:0] res_o
);

  logic [31:0] quo, rem;

  assign quo = dv_c_i[31:0];
  assign rem = dv_c_i[REM_HI:REM_LO];

  // Remainder follows the dividend sign; quotient is negative on sign mismatch
  always_comb begin
    if (op_rem(op_i)) res_o = a_neg_i ? (~rem + 32'd1) : rem;
    else              res_o = (a_neg_i ^ b_neg_i) ? (~quo + 32'd1) : quo;
  end

endmodule

// File: rtl/div_ctrl.sv
// Request-side controller for the iterative unsigned divider core. Handles
// divide-by-zero and signed overflow locally, otherwise issues magnitudes to
// the core and sign-corrects the captured result.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  div_op_t     req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        dv_valid,
  output logic [31:0] dv_a,
  output logic [31:0] dv_b,
  input  logic        dv_done,
  input  logic [63:0] dv_c
);

  div_state_t  state_q, state_d;
  div_op_t     op_q, op_d;
  logic        a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        dv_valid_q, dv_valid_d;
  logic [31:0] dv_a_q, dv_a_d, dv_b_q, dv_b_d;

  logic        accept, req_sgn, req_a_neg, req_b_neg, b_zero, ovf;
  logic [31:0] mag_a, mag_b, spec_res, fix_res;

  assign req_ready = (state_q == ST_IDLE) && !flush && resetn;
  assign accept    = req_valid && req_ready;

  assign req_sgn   = op_signed(req_op);
  assign req_a_neg = req_sgn && req_a[31];
  assign req_b_neg = req_sgn && req_b[31];
  assign mag_a     = req_a_neg ? (~req_a + 32'd1) : req_a;
  assign mag_b     = req_b_neg ? (~req_b + 32'd1) : req_b;
  assign b_zero    = (req_b == 32'd0);
  assign ovf       = req_sgn && (req_a == INT_MIN) && (req_b == NEG_ONE);

  // Locally resolved results; divide-by-zero takes precedence over overflow
  assign spec_res = b_zero ? (op_rem(req_op) ? req_a : NEG_ONE)
                           : (op_rem(req_op) ? 32'd0 : INT_MIN);

  div_sign_fix u_fix (
    .dv_c_i  (dv_c),
    .op_i    (op_q),
    .a_neg_i (a_neg_q),
    .b_neg_i (b_neg_q),
    .res_o   (fix_res)
  );

  // A flush in the issue cycle must keep the core from starting, so the
  // registered start pulse is gated by it.
  assign dv_valid   = dv_valid_q && !flush;
  assign dv_a       = dv_a_q;
  assign dv_b       = dv_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // Next-state and output-register decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_neg_d      = a_neg_q;
    b_neg_d      = b_neg_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    dv_valid_d   = 1'b0;
    dv_a_d       = dv_a_q;
    dv_b_d       = dv_b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          a_neg_d = req_a_neg;
          b_neg_d = req_b_neg;
          if (b_zero || ovf) begin
            resp_data_d  = spec_res;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            dv_a_d     = mag_a;
            dv_b_d     = mag_b;
            dv_valid_d = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        // Core cannot be aborted: a flushed op still has to be drained
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (dv_done) begin
          resp_data_d  = fix_res;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_DRAIN: if (dv_done) state_d = ST_IDLE;
      ST_RESP: begin
        if (resp_ready || flush) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_DIV;
      a_neg_q      <= 1'b0;
      b_neg_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      dv_valid_q   <= 1'b0;
      dv_a_q       <= 32'd0;
      dv_b_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_neg_q      <= a_neg_d;
      b_neg_q      <= b_neg_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      dv_valid_q   <= dv_valid_d;
      dv_a_q       <= dv_a_d;
      dv_b_q       <= dv_b_d;
    end
  end

endmodule
